// File: rtl/div_unit_if.sv
// Divide handshake between the execute stage (master) and div_unit (slave).
// Operands and start are driven by the master; result/ready come back registered.
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up at the end, returns {remainder, quotient} for HI/LO.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e             r_state;
    logic [CntW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic               r_signed;
    logic               r_sign1;
    logic               r_sign2;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_abort;

    // Quotient bits shift into r_dividend as dividend bits shift out of it.
    assign w_shift    = {r_rem, r_dividend[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_qbit     = ~w_diff[WIDTH];

    assign w_abs1     = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i
                                                                     : bus.opdata1_i;
    assign w_abs2     = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i
                                                                     : bus.opdata2_i;
    // Truncating division: remainder follows the dividend's sign.
    assign w_quot_fix = (r_signed && (r_sign1 ^ r_sign2)) ? -r_dividend : r_dividend;
    assign w_rem_fix  = (r_signed && r_sign1) ? -r_rem : r_rem;
    assign w_abort    = ~bus.start_i | bus.annul_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StFree;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_signed   <= 1'b0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            unique case (r_state)
                StFree: begin
                    r_ready  <= 1'b0;
                    r_result <= '0;
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata2_i == '0) begin
                            r_state <= StByZero;
                        end else begin
                            r_state    <= StOn;
                            r_cnt      <= '0;
                            r_dividend <= w_abs1;
                            r_divisor  <= w_abs2;
                            r_rem      <= '0;
                            r_signed   <= bus.signed_div_i;
                            r_sign1    <= bus.opdata1_i[WIDTH-1];
                            r_sign2    <= bus.opdata2_i[WIDTH-1];
                        end
                    end
                end
                StByZero: begin
                    if (w_abort) begin
                        r_state  <= StFree;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end else begin
                        r_state  <= StEnd;
                        r_ready  <= 1'b1;
                        r_result <= '0;
                    end
                end
                StOn: begin
                    if (w_abort) begin
                        r_state  <= StFree;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end else if (r_cnt != CntW'(WIDTH)) begin
                        r_rem      <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_dividend <= {r_dividend[WIDTH-2:0], w_qbit};
                        r_cnt      <= r_cnt + CntW'(1);
                    end else begin
                        r_result <= {w_rem_fix, w_quot_fix};
                        r_ready  <= 1'b1;
                        r_state  <= StEnd;
                    end
                end
                StEnd: begin
                    if (!bus.start_i) begin
                        r_state  <= StFree;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end
                end
                default: r_state <= StFree;
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by zero,
// abort, operand stability, reset mid-operation and back-to-back divides.
module tb_div_unit;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    div_unit_if #(.WIDTH(W)) bus ();
    div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive operands with start=1 and advance through edge 0.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = sgn;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        tick();
    endtask

    task automatic run_edges(input int n, output bit rose);
        rose = 1'b0;
        repeat (n) begin
            tick();
            if (bus.ready_o !== 1'b0) rose = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit rose;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
        bus.opdata1_i = '0; bus.opdata2_i = '0;
        tick(); tick();
        rst = 1'b0;
        n_total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
            $display("FAIL reset: got ready=%b result=%h want ready=0 result=0",
                     bus.ready_o, bus.result_o);
        else n_pass++;
        run_edges(5, rose);
        n_total++;
        if (rose) $display("FAIL reset_idle: got ready rise want none");
        else n_pass++;
    endtask

    task automatic test_signed();
        bit rose;
        launch(32'hFFFF_FFF9, 32'd2, 1'b1);
        run_edges(32, rose);
        n_total++;
        if (rose) $display("FAIL signed_latency: got ready before edge 33 want after");
        else n_pass++;
        tick();
        n_total++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
            $display("FAIL signed_result: got ready=%b result=%h want ready=1 result=%h",
                     bus.ready_o, bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        else n_pass++;
        // Held start keeps END; annul and operand changes are ignored there.
        bus.annul_i = 1'b1;
        bus.opdata1_i = 32'd5;
        tick(); tick(); tick();
        bus.annul_i = 1'b0;
        n_total++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
            $display("FAIL end_hold: got ready=%b result=%h want ready=1 result=%h",
                     bus.ready_o, bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        else n_pass++;
        bus.start_i = 1'b0;
        tick();
        n_total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
            $display("FAIL end_release: got ready=%b result=%h want ready=0 result=0",
                     bus.ready_o, bus.result_o);
        else n_pass++;
    endtask

    task automatic test_unsigned();
        bit rose;
        launch(32'hFFFF_FFFF, 32'h10, 1'b0);
        run_edges(32, rose);
        tick();
        n_total++;
        if (rose || bus.ready_o !== 1'b1 || bus.result_o !== {32'h0000_000F, 32'h0FFF_FFFF})
            $display("FAIL unsigned: got rose=%b ready=%b result=%h want rose=0 ready=1 result=%h",
                     rose, bus.ready_o, bus.result_o, {32'h0000_000F, 32'h0FFF_FFFF});
        else n_pass++;
        bus.start_i = 1'b0;
        tick();
        launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_edges(32, rose);
        tick();
        n_total++;
        if (rose || bus.ready_o !== 1'b1 || bus.result_o !== {32'h0, 32'h8000_0000})
            $display("FAIL overflow: got rose=%b ready=%b result=%h want rose=0 ready=1 result=%h",
                     rose, bus.ready_o, bus.result_o, {32'h0, 32'h8000_0000});
        else n_pass++;
        bus.start_i = 1'b0;
        tick();
    endtask

    task automatic test_div_zero();
        launch(32'd123, 32'd0, 1'b0);
        n_total++;
        if (bus.ready_o !== 1'b0)
            $display("FAIL divzero_edge0: got ready=%b want 0", bus.ready_o);
        else n_pass++;
        tick();
        n_total++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== 64'd0)
            $display("FAIL divzero_edge1: got ready=%b result=%h want ready=1 result=0",
                     bus.ready_o, bus.result_o);
        else n_pass++;
        tick(); tick();
        n_total++;
        if (bus.ready_o !== 1'b1)
            $display("FAIL divzero_hold: got ready=%b want 1", bus.ready_o);
        else n_pass++;
        bus.start_i = 1'b0;
        tick();
        n_total++;
        if (bus.ready_o !== 1'b0)
            $display("FAIL divzero_release: got ready=%b want 0", bus.ready_o);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit rose;
        bit rose2;
        launch(32'd100, 32'd7, 1'b0);
        run_edges(9, rose);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        tick();
        bus.annul_i = 1'b0;
        run_edges(30, rose2);
        n_total++;
        if (rose || rose2 || bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
            $display("FAIL abort: got rose=%b ready=%b result=%h want no rise, ready=0 result=0",
                     rose | rose2, bus.ready_o, bus.result_o);
        else n_pass++;
        launch(32'd100, 32'd7, 1'b0);
        run_edges(32, rose);
        tick();
        n_total++;
        if (rose || bus.ready_o !== 1'b1 || bus.result_o !== {32'd2, 32'd14})
            $display("FAIL after_abort: got rose=%b ready=%b result=%h want rose=0 ready=1 result=%h",
                     rose, bus.ready_o, bus.result_o, {32'd2, 32'd14});
        else n_pass++;
        bus.start_i = 1'b0;
        tick();
    endtask

    task automatic test_operand_change();
        bit rose;
        launch(32'd50, 32'd5, 1'b0);
        run_edges(4, rose);
        bus.opdata1_i = 32'hFFFF_FF00;
        bus.opdata2_i = 32'd3;
        bus.signed_div_i = 1'b1;
        run_edges(28, rose);
        tick();
        n_total++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== {32'd0, 32'd10})
            $display("FAIL operand_change: got ready=%b result=%h want ready=1 result=%h",
                     bus.ready_o, bus.result_o, {32'd0, 32'd10});
        else n_pass++;
        bus.start_i = 1'b0;
        tick();
        launch(32'd1000, 32'd3, 1'b0);
        run_edges(19, rose);
        bus.start_i = 1'b0;
        tick();
        n_total++;
        if (rose || bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
            $display("FAIL start_drop: got rose=%b ready=%b result=%h want no rise, ready=0 result=0",
                     rose, bus.ready_o, bus.result_o);
        else n_pass++;
        run_edges(20, rose);
        n_total++;
        if (rose) $display("FAIL start_drop_idle: got ready rise want none");
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit rose;
        launch(32'd77, 32'd5, 1'b0);
        run_edges(14, rose);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.start_i = 1'b0;
        n_total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
            $display("FAIL reset_mid: got ready=%b result=%h want ready=0 result=0",
                     bus.ready_o, bus.result_o);
        else n_pass++;
        run_edges(40, rose);
        n_total++;
        if (rose) $display("FAIL reset_mid_idle: got ready rise want none");
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit rose;
        launch(32'd9, 32'd2, 1'b0);
        run_edges(32, rose);
        tick();
        n_total++;
        if (rose || bus.result_o !== {32'd1, 32'd4})
            $display("FAIL b2b_first: got rose=%b result=%h want rose=0 result=%h",
                     rose, bus.result_o, {32'd1, 32'd4});
        else n_pass++;
        bus.start_i = 1'b0;
        tick();
        launch(32'hFFFF_FFF7, 32'd2, 1'b1);
        run_edges(32, rose);
        tick();
        n_total++;
        if (rose || bus.ready_o !== 1'b1 || bus.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFC})
            $display("FAIL b2b_second: got rose=%b ready=%b result=%h want rose=0 ready=1 result=%h",
                     rose, bus.ready_o, bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFC});
        else n_pass++;
        bus.start_i = 1'b0;
        tick();
        // Positive dividend, negative divisor: only the quotient flips sign.
        launch(32'd7, 32'hFFFF_FFFE, 1'b1);
        run_edges(32, rose);
        tick();
        n_total++;
        if (rose || bus.ready_o !== 1'b1 || bus.result_o !== {32'd1, 32'hFFFF_FFFD})
            $display("FAIL neg_divisor: got rose=%b ready=%b result=%h want rose=0 ready=1 result=%h",
                     rose, bus.ready_o, bus.result_o, {32'd1, 32'hFFFF_FFFD});
        else n_pass++;
        bus.start_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_div_zero();
        test_abort();
        test_operand_change();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle restoring divider.
- It is the responder side of the execute stage's divide handshake (opdata1/opdata2/start/signed in; result/ready out).
- Produces one quotient bit per cycle and returns {remainder, quotient} for the HI/LO write of DIV/DIVU.
- Sits beside the execute stage; the execute stage stalls the pipeline while ready_o is low and start_i is high.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
signed_div_i  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU)
opdata1_i  in  WIDTH  dividend
opdata2_i  in  WIDTH  divisor
start_i  in  1  1 = request/hold divide (DivStart), 0 = DivStop
annul_i  in  1  1 = cancel operation in flight (pipeline flush); tie 0 if unused
result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
ready_o  out  1  1 = result_o valid (DivResultReady)

Behaviour:
- Reset: rst, synchronous, active-high. It forces state FREE, ready_o=0, result_o=0, cnt=0.
- All outputs are registered.
- States: FREE, BYZERO, ON, END.

FREE:
- If start_i=1 and annul_i=0 and opdata2_i==0: go to BYZERO.
- Else if start_i=1 and annul_i=0: go to ON with cnt=0.
  - Latch |opdata1_i| and |opdata2_i|. Absolute value is taken only when signed_div_i=1 and the MSB is 1 (two's-complement negate).
  - Latch signed_div_i and both operand MSBs.
  - Initialise the partial remainder to 0.
- Otherwise stay in FREE; ready_o=0, result_o=0.

BYZERO:
- Next edge goes to END with result_o=0 and ready_o=1.
- If start_i=0 or annul_i=1 instead, go to FREE.

ON, while cnt<WIDTH:
- Shift {rem, dividend} left by 1.
- If rem >= divisor: rem -= divisor and set the quotient LSB to 1; else set it to 0.
- cnt++.

ON, when cnt==WIDTH:
- Apply the sign fix.
  - If signed and op1 MSB xor op2 MSB: negate the quotient.
  - If signed and op1 MSB: negate the remainder (remainder takes the dividend's sign, truncating division).
- result_o <= {rem, quot}; ready_o <= 1; go to END.

Abort:
- In ON or BYZERO, start_i=0 or annul_i=1 sends the block to FREE on the next edge.
- On abort: ready_o=0, result_o=0, partial work discarded. Abort takes priority over the iteration and completion steps.

END:
- Hold result_o and ready_o=1 while start_i=1.
- When start_i=0: go to FREE next edge, with ready_o=0 and result_o=0.
- annul_i is ignored in END.

Latency:
- Normal: the edge that samples start_i=1 in FREE is edge 0. ready_o is 1 after edge WIDTH+1 (33 for WIDTH=32).
- Divide by zero: ready_o is 1 after edge 1.

Other rules:
- Operand or signed_div_i changes after edge 0 are ignored until the block returns to FREE.
- A new divide requires start_i to return to 0 (one END→FREE cycle) before it is accepted. Back-to-back divides cost one idle cycle minimum.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient=0x80000000, remainder=0, no exception.
- Unsigned path never negates.

Test Plan:
1. Signed: opdata1=0xFFFFFFF9 (-7), opdata2=2, signed=1, start held. Required: ready_o=0 for 33 edges, then ready_o=1, result_o={0xFFFFFFFF, 0xFFFFFFFD}. After start=0: FREE, ready_o=0, result_o=0 next edge.
2. Unsigned: opdata1=0xFFFFFFFF, opdata2=0x10, signed=0. Required: result_o={0x0000000F, 0x0FFFFFFF} at edge 33. Then repeat with signed=1 and opdata2=0xFFFFFFFF on 0x80000000. Required: result_o={0x00000000, 0x80000000}.
3. Divide by zero: opdata1=123, opdata2=0, start=1. Required: ready_o=1 after edge 1, result_o=0. Holding start keeps END; dropping start returns to FREE.
4. Abort: start divide 100/7, then assert annul_i=1 at edge 10. Required: FREE next edge, ready_o never rises. A new divide 100/7 then gives {2, 14} at edge 33 after its start.
5. Start drop mid-operation and operand change: change opdata1 at edge 5 of 50/5. Required: result is still {0, 10}. Dropping start at edge 20 of a different divide gives FREE, ready_o=0.
6. Reset mid-operation: assert rst at edge 15 of a divide. Required: FREE, ready_o=0, result_o=0 the next edge. The block is idle until start is sampled again.
